// File: rtl/attn_value_matmul_pkg.sv
// -----------------------------------------------------------------------------
// attn_pkg
// Shared definitions for the attention datapath blocks:
//   FRAC_BITS_DEF : default number of fractional bits of the Q-format
//   ONE           : Q-format representation of 1.0
//   mv_state_t    : control states of the score x V matrix multiplier
//   sat_q()       : clamps a wide signed value into a DATA_WIDTH-bit range
// -----------------------------------------------------------------------------
package attn_pkg;

  localparam int FRAC_BITS_DEF = 14;
  localparam logic [31:0] ONE = 32'd1 << FRAC_BITS_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    STORE = 2'd2
  } mv_state_t;

  // Clamp x to [-2^(dw-1), 2^(dw-1)-1]; the caller keeps the low dw bits.
  function automatic logic signed [63:0] sat_q(input logic signed [63:0] x,
                                                input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 32'd1));
    if (x > hi) begin
      sat_q = hi;
    end else if (x < lo) begin
      sat_q = lo;
    end else begin
      sat_q = x;
    end
  endfunction

endpackage

// File: rtl/attn_value_matmul_if.sv
// -----------------------------------------------------------------------------
// attn_value_matmul_if
// Job handshake and flat matrix buses of the score x V multiplier.
//   start       : job request (master -> slave)
//   scores_flat : SEQ_LEN x SEQ_LEN unsigned scores (master -> slave)
//   v_flat      : SEQ_LEN x D_HEAD signed V matrix (master -> slave)
//   busy, done  : job status (slave -> master)
//   out_flat    : SEQ_LEN x D_HEAD signed result (slave -> master)
// -----------------------------------------------------------------------------
interface attn_value_matmul_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 64,
  parameter int D_HEAD     = 16
);

  logic                                   start;
  logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0]  scores_flat;
  logic [DATA_WIDTH*SEQ_LEN*D_HEAD-1:0]   v_flat;
  logic                                   busy;
  logic                                   done;
  logic [DATA_WIDTH*SEQ_LEN*D_HEAD-1:0]   out_flat;

  modport master (
    output start, scores_flat, v_flat,
    input  busy, done, out_flat
  );

  modport slave (
    input  start, scores_flat, v_flat,
    output busy, done, out_flat
  );

endinterface

// File: rtl/attn_value_matmul_mac_acc.sv
// -----------------------------------------------------------------------------
// attn_mac_acc
// Registered multiply-accumulate: acc += zext(a_i) * sext(b_i) when en_i,
// acc = 0 when clr_i (clear wins). res_o is the accumulator shifted right
// arithmetically by FRAC_BITS and saturated to DATA_WIDTH bits.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : clear accumulator
//   en_i     : accumulate one product
//   a_i      : unsigned operand
//   b_i      : signed operand
//   res_o    : saturated Q-format readout of the accumulator
// -----------------------------------------------------------------------------
module attn_mac_acc
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_W      = 2*DATA_WIDTH + 7,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic        [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] res_o
);

  localparam int PROD_W = 2*DATA_WIDTH + 1;

  logic signed [DATA_WIDTH:0] a_ext_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    shifted_s;
  logic signed [63:0]         sat_s;

  // Product and next accumulator value.
  always_comb begin
    a_ext_s = $signed({1'b0, a_i});
    prod_s  = PROD_W'(a_ext_s) * PROD_W'(b_i);
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Readout: floor division by 2^FRAC_BITS, then clamp.
  always_comb begin
    shifted_s = acc_q >>> FRAC_BITS;
    sat_s     = sat_q(64'(shifted_s), DATA_WIDTH);
    res_o     = sat_s[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/attn_value_matmul.sv
// -----------------------------------------------------------------------------
// attn_value_matmul
// Computes out = S x V for one attention head using a single time-multiplexed
// MAC. Each output element takes SEQ_LEN accumulate cycles plus one store
// cycle; elements are produced row-major (i outer, c inner).
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of attn_value_matmul_if (start/busy/done, scores,
//              V and result buses)
// Inputs are read directly from the bus every cycle, so the master must hold
// scores_flat and v_flat stable for the whole job.
// -----------------------------------------------------------------------------
module attn_value_matmul
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 64,
  parameter int D_HEAD     = 16,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  attn_value_matmul_if.slave bus
);

  localparam int IW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int CW    = (D_HEAD > 1) ? $clog2(D_HEAD) : 1;
  localparam int ACC_W = 2*DATA_WIDTH + $clog2(SEQ_LEN) + 1;
  localparam int OUT_W = DATA_WIDTH*SEQ_LEN*D_HEAD;

  localparam logic [IW-1:0] I_LAST = IW'(SEQ_LEN - 1);
  localparam logic [CW-1:0] C_LAST = CW'(D_HEAD - 1);

  mv_state_t         state_d, state_q;
  logic [IW-1:0]     i_d, i_q;
  logic [CW-1:0]     c_d, c_q;
  logic [IW-1:0]     k_d, k_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic [OUT_W-1:0]  out_d, out_q;

  logic                         mac_clr_s;
  logic                         mac_en_s;
  logic        [DATA_WIDTH-1:0] score_s;
  logic signed [DATA_WIDTH-1:0] value_s;
  logic signed [DATA_WIDTH-1:0] mac_res_s;
  int                           s_base_s;
  int                           v_base_s;
  int                           o_base_s;

  // Operand fetch: S[i][k] and V[k][c] straight from the input buses.
  always_comb begin
    s_base_s = (int'(i_q) * SEQ_LEN + int'(k_q)) * DATA_WIDTH;
    v_base_s = (int'(k_q) * D_HEAD + int'(c_q)) * DATA_WIDTH;
    o_base_s = (int'(i_q) * D_HEAD + int'(c_q)) * DATA_WIDTH;
    score_s  = bus.scores_flat[s_base_s +: DATA_WIDTH];
    value_s  = $signed(bus.v_flat[v_base_s +: DATA_WIDTH]);
  end

  attn_mac_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr_s),
    .en_i  (mac_en_s),
    .a_i   (score_s),
    .b_i   (value_s),
    .res_o (mac_res_s)
  );

  // Control FSM next-state, counter and output-register logic.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    c_d       = c_q;
    k_d       = k_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    out_d     = out_q;
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = MAC;
          i_d       = '0;
          c_d       = '0;
          k_d       = '0;
          busy_d    = 1'b1;
          mac_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      MAC: begin
        mac_en_s = 1'b1;
        if (k_q == I_LAST) begin
          state_d = STORE;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      STORE: begin
        out_d[o_base_s +: DATA_WIDTH] = mac_res_s;
        mac_clr_s = 1'b1;
        k_d       = '0;
        state_d   = MAC;
        if (c_q == C_LAST) begin
          c_d = '0;
          if (i_q == I_LAST) begin
            i_d     = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean idle.
        state_d   = IDLE;
        i_d       = '0;
        c_d       = '0;
        k_d       = '0;
        busy_d    = 1'b0;
        mac_clr_s = 1'b1;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      c_q     <= c_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.out_flat = out_q;

endmodule

// File: doc/attn_value_matmul.md
Name: attn_value_matmul

Overview:
Downstream neighbour of the softmax stage. Multiplies the SEQ_LEN x SEQ_LEN softmax score matrix by the SEQ_LEN x D_HEAD value matrix V, producing the SEQ_LEN x D_HEAD attention output for one head. It uses a single time-multiplexed MAC. Its `start` is driven by the softmax stage's `done`, and its flat input bus connects directly to `softmax_scores_flat`.

Parameters:
DATA_WIDTH, 16, bit width of every matrix element
SEQ_LEN, 64, sequence length (rows of scores, rows of V)
D_HEAD, 16, head dimension (columns of V and of the output)
FRAC_BITS, 14, fractional bits of all fixed-point operands and results

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  start request, sampled only in IDLE
scores_flat  input  DATA_WIDTH*SEQ_LEN*SEQ_LEN  softmax scores, unsigned Q(FRAC_BITS); element [m][n] at bits (m*SEQ_LEN+n)*DATA_WIDTH +: DATA_WIDTH
v_flat  input  DATA_WIDTH*SEQ_LEN*D_HEAD  V, signed Q(FRAC_BITS); element [k][c] at (k*D_HEAD+c)*DATA_WIDTH
busy  output  1  high while a computation is in progress
done  output  1  one-cycle pulse when all outputs are valid
out_flat  output  DATA_WIDTH*SEQ_LEN*D_HEAD  result, signed Q(FRAC_BITS); element [i][c] at (i*D_HEAD+c)*DATA_WIDTH

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, named `clk` and `rst`.
- Reset values: state=IDLE, busy=0, done=0, every out element 0, all counters and the accumulator 0.
- Reset mid-operation: same result as reset. No done is produced for the aborted job.
- States: IDLE, MAC, STORE.
- IDLE:
  - done=0 except for the pulse cycle.
  - start=1 at edge E0 → clear acc, set i=c=k=0, go to MAC, busy=1 from the next cycle.
- MAC (one product per cycle):
  - acc += S[i][k]*V[k][c], with S zero-extended and V sign-extended.
  - product width 2*DATA_WIDTH+1; accumulator width 2*DATA_WIDTH+$clog2(SEQ_LEN)+1, signed.
  - At k==SEQ_LEN-1 go to STORE; otherwise k++.
- STORE:
  - out[i][c] = sat(acc >>> FRAC_BITS), an arithmetic shift with truncation toward -inf.
  - Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Then clear acc and set k=0.
  - Advance c; on wrap (c==D_HEAD-1) set c=0 and advance i.
  - If i==SEQ_LEN-1 and c==D_HEAD-1: done<=1, busy<=0, go to IDLE. Otherwise go to MAC.
- Latency:
  - Each element takes SEQ_LEN+1 cycles.
  - done is high in the cycle after edge E0+SEQ_LEN*D_HEAD*(SEQ_LEN+1), for exactly one cycle.
- Output register behaviour:
  - Out elements update individually during the run; out_flat is only guaranteed coherent once done is high.
  - Outputs hold until the next job overwrites them.
- start while busy is ignored; no queuing.
- start high in the cycle done is high is accepted (state is already IDLE), so back-to-back jobs are legal.
- scores_flat and v_flat must be held stable from E0 until done; the block does not latch them.
- Unknown or illegal state → IDLE.

Decomposition:
- Package attn_pkg holds:
  - FRAC_BITS default;
  - Q-format ONE constant (1<<FRAC_BITS);
  - the saturation bounds function sat_q;
  - typedef mv_state_t {IDLE, MAC, STORE}.
- One sub-module, attn_mac_acc: registered multiply-accumulate with clear and saturating-shift readout. It is reusable by the upstream QK^T score stage.

Test Plan:
- SEQ_LEN=4, D_HEAD=2, scores = identity (diagonal 16384, else 0), V = [[100,-200],[300,-400],[500,-600],[700,-800]] → out == V; done high exactly 40 cycles after start edge, busy high for those 40 cycles.
- All scores 4096 (0.25), V column 0 = {4096,8192,12288,16384}, column 1 = all -16384 → every row out = {10240,-16384}.
- All scores 16384, V all 24576 → out all 32767 (positive saturation); V all -16384 → out all -32768 (negative saturation).
- Pulse start again at cycles 5 and 20 of a running job → ignored; exactly one done at cycle 40, results unchanged.
- Assert rst at cycle 17 of a job → next cycle busy=0, done=0, all out=0; no done follows; a new start then completes normally in 40 cycles.
- Assert start in the done cycle with new V → second job runs immediately, second done 40 cycles later with the new results.
